// File: rtl/pipeline_fwd.sv
// Purpose: 4-stage in-order core (IF, ID, EX/MEM, WB) with register file, full forwarding, ID-stage branches and HALT drain.
// Latency: fetched at edge N, result forwardable to the next instruction's ID with no stall, regfile written at edge N+3.
// Backpressure: none; memories never stall, a taken branch inserts one bubble, HALT freezes fetch until reset.
module pipeline_fwd #(
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           DATA_WIDTH        = 64,
    parameter int                           NUM_REGS          = 32,
    parameter logic [INSTRUCTION_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
    output logic [INSTRUCTION_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0]        dmem_dataOut,
    output logic [INSTRUCTION_WIDTH-1:0] dmem_address,
    output logic [DATA_WIDTH-1:0]        dmem_dataIn,
    output logic                         dmem_rd_en,
    output logic                         dmem_wr_en,
    output logic                         halted,
    output logic [31:0]                  retired_count
);

    localparam int IW = INSTRUCTION_WIDTH;
    localparam int DW = DATA_WIDTH;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SLL  = 6'd6;
    localparam logic [5:0] OP_ADDI = 6'd7;
    localparam logic [5:0] OP_LD   = 6'd8;
    localparam logic [5:0] OP_SD   = 6'd9;
    localparam logic [5:0] OP_BEZ  = 6'd10;
    localparam logic [5:0] OP_HALT = 6'd11;

    localparam logic [IW-1:0] PC_STEP = IW'(4);

    // IF/ID: fetched instruction and the PC it came from
    typedef struct packed {
        logic          vld;
        logic [IW-1:0] ins;
        logic [IW-1:0] pc;
    } s1_t;

    // ID/EX: decoded op with forwarded operands
    typedef struct packed {
        logic          vld;
        logic          wr_en;
        logic [5:0]    op;
        logic [4:0]    rd;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
    } s2_t;

    // EX/WB: result waiting for the register file
    typedef struct packed {
        logic          vld;
        logic          wr_en;
        logic          is_halt;
        logic [4:0]    rd;
        logic [DW-1:0] res;
    } s3_t;

    logic [IW-1:0] pc;
    logic          halt_seen;
    s1_t           s1;
    s2_t           s2;
    s3_t           s3;
    logic [DW-1:0] rf [NUM_REGS];

    // ID decode fields
    logic [5:0]    id_op;
    logic [4:0]    id_rd;
    logic [4:0]    id_ra;
    logic [4:0]    id_rb;
    logic [15:0]   id_imm;
    logic [DW-1:0] id_sext;
    logic [IW-1:0] id_sext_pc;
    logic          id_wr_en;

    // forwarded operand values
    logic [DW-1:0] val_a;
    logic [DW-1:0] val_b;
    logic [DW-1:0] val_d;

    logic [DW-1:0] ex_res;
    logic          br_taken;
    logic [IW-1:0] br_target;
    logic          halt_now;
    logic          fetch_stop;

    assign id_op      = s1.ins[31:26];
    assign id_rd      = s1.ins[25:21];
    assign id_ra      = s1.ins[20:16];
    assign id_rb      = s1.ins[15:11];
    assign id_imm     = s1.ins[15:0];
    assign id_sext    = {{(DW-16){id_imm[15]}}, id_imm};
    assign id_sext_pc = {{(IW-16){id_imm[15]}}, id_imm};
    assign id_wr_en   = (id_op >= OP_ADD) && (id_op <= OP_LD);

    assign imem_address = pc;

    // EX: ALU result, or the load data returned by dmem this cycle
    always_comb begin
        ex_res = '0;
        case (s2.op)
            OP_ADD:  ex_res = s2.opa + s2.opb;
            OP_SUB:  ex_res = s2.opa - s2.opb;
            OP_AND:  ex_res = s2.opa & s2.opb;
            OP_OR:   ex_res = s2.opa | s2.opb;
            OP_XOR:  ex_res = s2.opa ^ s2.opb;
            OP_SLL:  ex_res = s2.opa << s2.opb[5:0];
            OP_ADDI: ex_res = s2.opa + s2.opb;
            OP_LD:   ex_res = dmem_dataOut;
            default: ex_res = '0;
        endcase
    end

    // Register read with forwarding: EX result first, then WB write-through, then the array.
    // r0 and unimplemented indices always read as zero, even if something in flight names them.
    function automatic logic [DW-1:0] fwd(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NUM_REGS)
            return '0;
        else if (s2.vld && s2.wr_en && s2.rd == idx)
            return ex_res;
        else if (s3.vld && s3.wr_en && s3.rd == idx)
            return s3.res;
        else
            return rf[idx];
    endfunction

    // ID: operand fetch, memory request, branch and halt decisions
    always_comb begin
        val_a        = fwd(id_ra);
        val_b        = fwd(id_rb);
        val_d        = fwd(id_rd);
        dmem_address = val_a[IW-1:0] + id_sext[IW-1:0];
        dmem_dataIn  = val_d;
        dmem_rd_en   = s1.vld && (id_op == OP_LD);
        dmem_wr_en   = s1.vld && (id_op == OP_SD);
        br_taken     = s1.vld && (id_op == OP_BEZ) && (val_a == '0);
        br_target    = s1.pc + (id_sext_pc << 2);
        halt_now     = s1.vld && (id_op == OP_HALT);
        fetch_stop   = br_taken || halt_now || halt_seen;
    end

    // IF: advance or redirect the PC and capture the fetched word; squash it on branch/halt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            halt_seen <= 1'b0;
            s1        <= '0;
        end else begin
            halt_seen <= halt_seen | halt_now;
            if (br_taken)
                pc <= br_target;
            else if (!(halt_now || halt_seen))
                pc <= pc + PC_STEP;
            s1.vld <= !fetch_stop;
            s1.ins <= imem_instruction;
            s1.pc  <= pc;
        end
    end

    // ID -> EX: latch decoded op; ADDI takes the immediate as its second operand
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2 <= '0;
        end else begin
            s2.vld   <= s1.vld;
            s2.wr_en <= s1.vld && id_wr_en;
            s2.op    <= id_op;
            s2.rd    <= id_rd;
            s2.opa   <= val_a;
            s2.opb   <= (id_op == OP_ADDI) ? id_sext : val_b;
        end
    end

    // EX -> WB: latch the result and write intent
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3 <= '0;
        end else begin
            s3.vld     <= s2.vld;
            s3.wr_en   <= s2.vld && s2.wr_en;
            s3.is_halt <= s2.vld && (s2.op == OP_HALT);
            s3.rd      <= s2.rd;
            s3.res     <= ex_res;
        end
    end

    // WB: register file write; r0 and unimplemented indices are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] <= '0;
        end else if (s3.vld && s3.wr_en && s3.rd != 5'd0 && int'(s3.rd) < NUM_REGS) begin
            rf[s3.rd] <= s3.res;
        end
    end

    // WB: retirement counter and sticky halt flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_count <= '0;
            halted        <= 1'b0;
        end else begin
            if (s3.vld)
                retired_count <= retired_count + 32'd1;
            if (s3.is_halt)
                halted <= 1'b1;
        end
    end

endmodule
